// File: rtl/vector_recorder_8bits.sv
// Trace recorder: captures {clk_in, q_in} samples into an on-chip buffer while armed,
// then plays the captured words back in order over a valid/ready stream.
module vector_recorder_8bits #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clkSimulation,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clk_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic              rd_req,
    output logic [DATA_W:0]   vec_out,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, DUMP} state_t;

    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              writeEn;
    logic              lastWord;

    logic [DATA_W:0]   mem [DEPTH];

    // Writes are suppressed on a reset edge so reset wins over an in-flight capture.
    assign writeEn  = rst && (state_q == CAPTURE) && !stop;
    assign lastWord = ({1'b0, rdPtr_q} == (count_q - 1'b1));

    always_ff @(posedge clkSimulation) begin
        if (!rst) begin
            state_q <= IDLE;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clkSimulation) begin
        if (writeEn) begin
            mem[wrPtr_q] <= {clk_in, q_in};
        end
    end

    always_comb begin
        state_d = state_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        full_d  = full_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                    wrPtr_d = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    state_d = HOLD;
                end else begin
                    wrPtr_d = wrPtr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_SLOT) begin
                        state_d = HOLD;
                        full_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (rd_req) begin
                    // An empty capture completes immediately without presenting any word.
                    if (count_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DUMP;
                        rdPtr_d = '0;
                    end
                end
            end
            DUMP: begin
                if (vec_ready) begin
                    rdPtr_d = rdPtr_q + 1'b1;
                    if (lastWord) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == CAPTURE) || (state_q == DUMP);
        vec_valid = (state_q == DUMP);
        vec_out   = (state_q == DUMP) ? mem[rdPtr_q] : '0;
        full      = full_q;
        count     = count_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_vector_recorder_8bits.sv
// Self-checking bench for vector_recorder_8bits: a directed vector table for reset and
// empty-capture handling, plus hand-written sequences for full capture, stalls and reset mid-dump.
module tb_vector_recorder_8bits;

    logic       clkSimulation;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clkIn;
    logic [7:0] qIn;
    logic       rdReq;
    logic [8:0] vecOut;
    logic       vecValid;
    logic       vecReady;
    logic       busy;
    logic       full;
    logic [9:0] count;
    logic       done;

    int compared;
    int mismatched;

    typedef struct {
        logic       rstN;
        logic       start;
        logic       stop;
        logic       clkIn;
        logic [7:0] qIn;
        logic       rdReq;
        logic       vecReady;
        logic [9:0] expCount;
        logic       expFull;
        logic       expBusy;
        logic       expDone;
        logic       expValid;
        logic [8:0] expOut;
    } vecRec_t;

    vecRec_t vecTable [8];

    vector_recorder_8bits dut (
        .clkSimulation (clkSimulation),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .clk_in        (clkIn),
        .q_in          (qIn),
        .rd_req        (rdReq),
        .vec_out       (vecOut),
        .vec_valid     (vecValid),
        .vec_ready     (vecReady),
        .busy          (busy),
        .full          (full),
        .count         (count),
        .done          (done)
    );

    initial clkSimulation = 1'b0;
    always #5 clkSimulation = ~clkSimulation;

    task automatic step();
        @(posedge clkSimulation);
        #1;
    endtask

    task automatic applyStimulus(input logic rstN, input logic st, input logic sp,
                                 input logic ck, input logic [7:0] q,
                                 input logic rr, input logic vr);
        rst      = rstN;
        start    = st;
        stop     = sp;
        clkIn    = ck;
        qIn      = q;
        rdReq    = rr;
        vecReady = vr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [9:0] eCount, input logic eFull,
                            input logic eBusy, input logic eDone, input logic eValid,
                            input logic [8:0] eOut);
        checkOutput({tag, " count"}, 32'(count), 32'(eCount));
        checkOutput({tag, " full"}, 32'(full), 32'(eFull));
        checkOutput({tag, " busy"}, 32'(busy), 32'(eBusy));
        checkOutput({tag, " done"}, 32'(done), 32'(eDone));
        checkOutput({tag, " vec_valid"}, 32'(vecValid), 32'(eValid));
        checkOutput({tag, " vec_out"}, 32'(vecOut), 32'(eOut));
    endtask

    initial begin
        logic [8:0] expWord;
        int         transfers;
        int         cycles;

        compared   = 0;
        mismatched = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // rst, start, stop, clk, q, rd_req, ready | count, full, busy, done, valid, out
        vecTable[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
        vecTable[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
        vecTable[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
        vecTable[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000};
        vecTable[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
        vecTable[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000};
        vecTable[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
        vecTable[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};

        $display("[TB] vector table: reset and empty capture");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecTable[i].rstN, vecTable[i].start, vecTable[i].stop, vecTable[i].clkIn,
                          vecTable[i].qIn, vecTable[i].rdReq, vecTable[i].vecReady);
            step();
            checkAll($sformatf("vec%0d", i), vecTable[i].expCount, vecTable[i].expFull,
                     vecTable[i].expBusy, vecTable[i].expDone, vecTable[i].expValid,
                     vecTable[i].expOut);
        end

        $display("[TB] full-depth capture");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        checkAll("arm", 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
        start = 1'b0;
        for (int i = 0; i < 512; i++) begin
            clkIn = i[0];
            qIn   = i[7:0];
            step();
            if (i == 0) checkAll("cap first", 10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
            if (i == 510) checkAll("cap 511", 10'd511, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
        end
        checkAll("cap full", 10'd512, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        clkIn = 1'b1;
        qIn   = 8'hFF;
        step();
        checkAll("cap 513th dropped", 10'd512, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);

        $display("[TB] full-depth playback");
        rdReq = 1'b1;
        step();
        rdReq    = 1'b0;
        vecReady = 1'b1;
        for (int i = 0; i < 512; i++) begin
            expWord = {i[0], i[7:0]};
            checkOutput($sformatf("dump%0d valid", i), 32'(vecValid), 32'd1);
            checkOutput($sformatf("dump%0d word", i), 32'(vecOut), 32'(expWord));
            checkOutput($sformatf("dump%0d done", i), 32'(done), 32'd0);
            step();
        end
        checkAll("dump end", 10'd512, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
        vecReady = 1'b0;
        step();
        checkAll("dump after", 10'd512, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);

        $display("[TB] short capture with stalled playback");
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clkIn = k[0];
            qIn   = 8'hA0 + 8'(k);
            step();
        end
        stop  = 1'b1;
        clkIn = 1'b1;
        qIn   = 8'hEE;
        step();
        stop = 1'b0;
        checkAll("short hold", 10'd10, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        rdReq = 1'b1;
        step();
        rdReq     = 1'b0;
        transfers = 0;
        cycles    = 0;
        while (transfers < 10 && cycles < 100) begin
            vecReady = (cycles % 2 == 0);
            expWord  = {transfers[0], 8'hA0 + 8'(transfers)};
            checkOutput($sformatf("stall c%0d valid", cycles), 32'(vecValid), 32'd1);
            checkOutput($sformatf("stall c%0d word", cycles), 32'(vecOut), 32'(expWord));
            checkOutput($sformatf("stall c%0d done", cycles), 32'(done), 32'd0);
            if (vecReady) transfers++;
            step();
            cycles++;
        end
        checkOutput("stall transfers", 32'(transfers), 32'd10);
        checkAll("stall end", 10'd10, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
        vecReady = 1'b0;
        step();
        checkAll("stall after", 10'd10, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);

        $display("[TB] reset during playback");
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clkIn = 1'b0;
            qIn   = 8'h50 + 8'(k);
            step();
        end
        stop = 1'b1;
        step();
        stop  = 1'b0;
        rdReq = 1'b1;
        step();
        rdReq    = 1'b0;
        vecReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("pre-rst word%0d", k), 32'(vecOut), 32'({1'b0, 8'h50 + 8'(k)}));
            step();
        end
        rst      = 1'b0;
        vecReady = 1'b0;
        step();
        checkAll("mid-dump rst", 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        rst = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        clkIn = 1'b1;
        qIn   = 8'h77;
        step();
        qIn = 8'h78;
        clkIn = 1'b0;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checkAll("recap hold", 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        rdReq = 1'b1;
        step();
        rdReq = 1'b0;
        checkAll("recap word0", 10'd2, 1'b0, 1'b1, 1'b0, 1'b1, 9'h177);
        vecReady = 1'b1;
        step();
        checkAll("recap word1", 10'd2, 1'b0, 1'b1, 1'b0, 1'b1, 9'h078);
        step();
        checkAll("recap end", 10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
        vecReady = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
